// File: rtl/food_placer.sv
// food_placer: picks a free playfield cell for the next food item.
// Random LFSR draws are tried first, and each in-range candidate is checked
// against the snake body through a valid/ready occupancy query. After
// MAX_TRIES failed attempts the block walks the grid row-major until it finds
// a free cell or proves that the grid is full.
module food_placer #(
  parameter int GRID_W    = 40,
  parameter int GRID_H    = 30,
  parameter int CW        = 6,
  parameter int MAX_TRIES = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          place_req,
  input  logic [9:0]    rnd_x,
  input  logic [9:0]    rnd_y,
  output logic          q_valid,
  input  logic          q_ready,
  output logic [CW-1:0] q_x,
  output logic [CW-1:0] q_y,
  input  logic          resp_valid,
  input  logic          resp_occupied,
  output logic [CW-1:0] food_x,
  output logic [CW-1:0] food_y,
  output logic          food_valid,
  output logic          busy,
  output logic          grid_full
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SAMPLE = 3'd1;
  localparam logic [2:0] S_QUERY  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_SCAN   = 3'd4;
  localparam logic [2:0] S_SWAIT  = 3'd5;

  // One extra bit so a full CW-bit draw can be compared against the grid size.
  localparam logic [CW:0]   GW     = (CW+1)'(GRID_W);
  localparam logic [CW:0]   GH     = (CW+1)'(GRID_H);
  localparam logic [CW-1:0] LAST_X = CW'(GRID_W - 1);
  localparam logic [CW-1:0] LAST_Y = CW'(GRID_H - 1);
  localparam logic [7:0]    MAX_T  = 8'(MAX_TRIES);

  logic [2:0]    state;
  logic [7:0]    tries;
  logic [7:0]    tries_next;
  logic [CW-1:0] cx;
  logic [CW-1:0] cy;
  logic          in_range;
  logic          last_try;
  logic          last_x;
  logic          last_cell;
  logic          unused_rnd;

  // Only the low CW bits of each LFSR word form a candidate coordinate.
  assign cx         = rnd_x[CW-1:0];
  assign cy         = rnd_y[CW-1:0];
  assign unused_rnd = ^{rnd_x, rnd_y};
  assign in_range   = ({1'b0, cx} < GW) && ({1'b0, cy} < GH);

  // Range rejections and occupied answers share one attempt budget.
  assign tries_next = tries + 8'd1;
  assign last_try   = (tries_next == MAX_T);
  assign last_x     = (q_x == LAST_X);
  assign last_cell  = last_x && (q_y == LAST_Y);

  // Every state other than IDLE is part of a placement.
  assign busy = (state != S_IDLE);

  // Placement sequencer: random draws, occupancy handshake, scan fallback, commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      tries      <= '0;
      q_valid    <= 1'b0;
      q_x        <= '0;
      q_y        <= '0;
      food_x     <= '0;
      food_y     <= '0;
      food_valid <= 1'b0;
      grid_full  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (place_req) begin
            state      <= S_SAMPLE;
            food_valid <= 1'b0;
            grid_full  <= 1'b0;
            tries      <= '0;
          end
        end

        S_SAMPLE: begin
          if (in_range) begin
            q_x     <= cx;
            q_y     <= cy;
            q_valid <= 1'b1;
            state   <= S_QUERY;
          end else begin
            tries <= tries_next;
            if (last_try) begin
              q_x     <= '0;
              q_y     <= '0;
              q_valid <= 1'b1;
              state   <= S_SCAN;
            end
          end
        end

        S_QUERY: begin
          if (q_ready) begin
            q_valid <= 1'b0;
            state   <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (resp_valid) begin
            if (!resp_occupied) begin
              food_x     <= q_x;
              food_y     <= q_y;
              food_valid <= 1'b1;
              state      <= S_IDLE;
            end else begin
              tries <= tries_next;
              if (last_try) begin
                q_x     <= '0;
                q_y     <= '0;
                q_valid <= 1'b1;
                state   <= S_SCAN;
              end else begin
                state <= S_SAMPLE;
              end
            end
          end
        end

        S_SCAN: begin
          if (q_ready) begin
            q_valid <= 1'b0;
            state   <= S_SWAIT;
          end
        end

        S_SWAIT: begin
          if (resp_valid) begin
            if (!resp_occupied) begin
              food_x     <= q_x;
              food_y     <= q_y;
              food_valid <= 1'b1;
              state      <= S_IDLE;
            end else if (last_cell) begin
              grid_full <= 1'b1;
              state     <= S_IDLE;
            end else begin
              if (last_x) begin
                q_x <= '0;
                q_y <= q_y + 1'b1;
              end else begin
                q_x <= q_x + 1'b1;
              end
              q_valid <= 1'b1;
              state   <= S_SCAN;
            end
          end
        end

        default: begin
          state   <= S_IDLE;
          q_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_food_placer.sv
// tb_food_placer: directed scenarios for the food placer, with a small
// occupancy responder standing in for the snake body store.
module tb_food_placer;

  localparam int GW = 40;
  localparam int GH = 30;
  localparam int CW = 6;

  logic          clk;
  logic          rst_n;
  logic          place_req;
  logic [9:0]    rnd_x;
  logic [9:0]    rnd_y;
  logic          q_valid;
  logic          q_ready;
  logic [CW-1:0] q_x;
  logic [CW-1:0] q_y;
  logic          resp_valid;
  logic          resp_occupied;
  logic [CW-1:0] food_x;
  logic [CW-1:0] food_y;
  logic          food_valid;
  logic          busy;
  logic          grid_full;

  int checks;
  int errors;

  bit occ [0:GH-1][0:GW-1];
  int query_count;
  logic [CW-1:0] log_x [0:4095];
  logic [CW-1:0] log_y [0:4095];
  int stall_idx;
  int stall_left;

  food_placer #(.GRID_W(GW), .GRID_H(GH), .CW(CW), .MAX_TRIES(64)) dut (
    .clk(clk), .rst_n(rst_n), .place_req(place_req),
    .rnd_x(rnd_x), .rnd_y(rnd_y),
    .q_valid(q_valid), .q_ready(q_ready), .q_x(q_x), .q_y(q_y),
    .resp_valid(resp_valid), .resp_occupied(resp_occupied),
    .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
    .busy(busy), .grid_full(grid_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Occupancy responder: logs accepted queries and answers one cycle later.
  initial begin
    bit acc;
    bit acc_occ;
    q_ready       = 1'b1;
    resp_valid    = 1'b0;
    resp_occupied = 1'b0;
    query_count   = 0;
    stall_idx     = -1;
    stall_left    = 0;
    forever begin
      @(posedge clk);
      acc     = 1'b0;
      acc_occ = 1'b0;
      if (rst_n && q_valid && q_ready) begin
        acc = 1'b1;
        if (q_x < GW && q_y < GH) acc_occ = occ[q_y][q_x];
        else acc_occ = 1'b1;
        if (query_count < 4096) begin
          log_x[query_count] = q_x;
          log_y[query_count] = q_y;
        end
        query_count++;
      end
      @(negedge clk);
      resp_valid    = acc;
      resp_occupied = acc ? acc_occ : 1'b0;
      if (stall_left > 0 && q_valid && query_count == stall_idx) begin
        q_ready = 1'b0;
        stall_left--;
      end else begin
        q_ready = 1'b1;
      end
    end
  end

  task automatic set_all_occ(input bit v);
    for (int y = 0; y < GH; y++)
      for (int x = 0; x < GW; x++)
        occ[y][x] = v;
  endtask

  // Leaves the bench just after the negedge that follows the request edge.
  task automatic pulse_req();
    @(negedge clk);
    place_req = 1'b1;
    @(negedge clk);
    place_req = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      #1;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({q_valid, busy, food_valid, grid_full, food_x, food_y, q_x, q_y} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state: got qv=%b busy=%b fv=%b gf=%b food=(%0d,%0d) q=(%0d,%0d), need all 0",
               q_valid, busy, food_valid, grid_full, food_x, food_y, q_x, q_y);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_hit();
    int base;
    base = query_count;
    rnd_x = 10'd5; rnd_y = 10'd7;
    set_all_occ(1'b0);
    pulse_req();
    #1;
    checks++;
    if (busy !== 1'b1 || food_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hit_after_e0: busy=%b fv=%b, need busy=1 fv=0", busy, food_valid);
    end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (food_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hit_after_e2: fv=%b busy=%b, need fv=0 busy=1", food_valid, busy);
    end
    @(negedge clk);
    #1;
    checks++;
    if (food_valid !== 1'b1 || busy !== 1'b0 || food_x !== 6'd5 || food_y !== 6'd7) begin
      errors++;
      $display("[TB] FAIL hit_commit_e3: fv=%b busy=%b food=(%0d,%0d), need fv=1 busy=0 food=(5,7)",
               food_valid, busy, food_x, food_y);
    end
    checks++;
    if (query_count - base != 1 || log_x[base] !== 6'd5 || log_y[base] !== 6'd7) begin
      errors++;
      $display("[TB] FAIL hit_queries: count=%0d first=(%0d,%0d), need count=1 (5,7)",
               query_count - base, log_x[base], log_y[base]);
    end
  endtask

  task automatic test_range_reject();
    int base;
    bit ok;
    bit saw_q;
    base = query_count;
    saw_q = 1'b0;
    rnd_x = 10'd45; rnd_y = 10'd3;
    pulse_req();
    repeat (3) begin
      @(negedge clk);
      if (q_valid) saw_q = 1'b1;
    end
    rnd_x = 10'd12;
    checks++;
    if (saw_q || query_count != base) begin
      errors++;
      $display("[TB] FAIL reject_no_query: q_valid seen=%b count=%0d, need 0 and 0", saw_q, query_count - base);
    end
    wait_idle(50, ok);
    checks++;
    if (!ok || food_valid !== 1'b1 || food_x !== 6'd12 || food_y !== 6'd3 ||
        query_count - base != 1 || log_x[base] !== 6'd12 || log_y[base] !== 6'd3) begin
      errors++;
      $display("[TB] FAIL reject_commit: done=%b fv=%b food=(%0d,%0d) count=%0d, need 1 1 (12,3) 1",
               ok, food_valid, food_x, food_y, query_count - base);
    end
  endtask

  task automatic test_retry_stall();
    int base;
    bit ok;
    bit found;
    base = query_count;
    set_all_occ(1'b0);
    occ[4][10] = 1'b1;
    rnd_x = 10'd10; rnd_y = 10'd4;
    stall_idx  = base + 1;
    stall_left = 4;
    pulse_req();
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (query_count == base + 1) begin
        found = 1'b1;
        break;
      end
    end
    rnd_x = 10'd20; rnd_y = 10'd6;
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL retry_first_query: count=%0d, need 1", query_count - base);
    end
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (q_valid) begin
        found = 1'b1;
        break;
      end
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (!found || q_valid !== 1'b1 || q_x !== 6'd20 || q_y !== 6'd6) begin
        errors++;
        $display("[TB] FAIL stall_hold[%0d]: qv=%b q=(%0d,%0d), need qv=1 (20,6)", i, q_valid, q_x, q_y);
      end
      @(negedge clk);
      #1;
    end
    wait_idle(50, ok);
    checks++;
    if (!ok || food_x !== 6'd20 || food_y !== 6'd6 || food_valid !== 1'b1 || query_count - base != 2) begin
      errors++;
      $display("[TB] FAIL retry_commit: done=%b fv=%b food=(%0d,%0d) count=%0d, need 1 1 (20,6) 2",
               ok, food_valid, food_x, food_y, query_count - base);
    end
  endtask

  task automatic test_fallback_scan();
    int base;
    bit ok;
    base = query_count;
    set_all_occ(1'b1);
    occ[1][2] = 1'b0;
    rnd_x = 10'd5; rnd_y = 10'd7;
    pulse_req();
    wait_idle(2000, ok);
    checks++;
    if (!ok || query_count - base != 107) begin
      errors++;
      $display("[TB] FAIL scan_count: done=%b count=%0d, need 1 107", ok, query_count - base);
    end
    checks++;
    if (log_x[base+63] !== 6'd5 || log_y[base+63] !== 6'd7 ||
        log_x[base+64] !== 6'd0 || log_y[base+64] !== 6'd0 ||
        log_x[base+105] !== 6'd1 || log_y[base+105] !== 6'd1 ||
        log_x[base+106] !== 6'd2 || log_y[base+106] !== 6'd1) begin
      errors++;
      $display("[TB] FAIL scan_order: q64=(%0d,%0d) q65=(%0d,%0d) q106=(%0d,%0d) q107=(%0d,%0d), need (5,7) (0,0) (1,1) (2,1)",
               log_x[base+63], log_y[base+63], log_x[base+64], log_y[base+64],
               log_x[base+105], log_y[base+105], log_x[base+106], log_y[base+106]);
    end
    checks++;
    if (food_valid !== 1'b1 || grid_full !== 1'b0 || food_x !== 6'd2 || food_y !== 6'd1) begin
      errors++;
      $display("[TB] FAIL scan_commit: fv=%b gf=%b food=(%0d,%0d), need 1 0 (2,1)",
               food_valid, grid_full, food_x, food_y);
    end
  endtask

  task automatic test_full_grid();
    int base;
    bit ok;
    base = query_count;
    set_all_occ(1'b1);
    rnd_x = 10'd5; rnd_y = 10'd7;
    pulse_req();
    wait_idle(6000, ok);
    checks++;
    if (!ok || query_count - base != 1264) begin
      errors++;
      $display("[TB] FAIL full_count: done=%b count=%0d, need 1 1264", ok, query_count - base);
    end
    checks++;
    if (grid_full !== 1'b1 || food_valid !== 1'b0 || busy !== 1'b0 || food_x !== 6'd2 || food_y !== 6'd1 ||
        log_x[base+1263] !== 6'd39 || log_y[base+1263] !== 6'd29) begin
      errors++;
      $display("[TB] FAIL full_flags: gf=%b fv=%b busy=%b food=(%0d,%0d) last=(%0d,%0d), need 1 0 0 (2,1) (39,29)",
               grid_full, food_valid, busy, food_x, food_y, log_x[base+1263], log_y[base+1263]);
    end
    set_all_occ(1'b0);
    pulse_req();
    #1;
    checks++;
    if (grid_full !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL full_clear: gf=%b busy=%b, need 0 1", grid_full, busy);
    end
    wait_idle(50, ok);
    checks++;
    if (!ok || food_valid !== 1'b1 || food_x !== 6'd5 || food_y !== 6'd7) begin
      errors++;
      $display("[TB] FAIL full_recover: done=%b fv=%b food=(%0d,%0d), need 1 1 (5,7)", ok, food_valid, food_x, food_y);
    end
  endtask

  task automatic test_reset_and_ignore();
    int base;
    set_all_occ(1'b0);
    rnd_x = 10'd5; rnd_y = 10'd7;
    pulse_req();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || q_valid !== 1'b0 || resp_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pre_reset_wait: busy=%b qv=%b rv=%b, need 1 0 1", busy, q_valid, resp_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({q_valid, busy, food_valid, grid_full, food_x, food_y, q_x, q_y} !== '0) begin
      errors++;
      $display("[TB] FAIL async_reset: qv=%b busy=%b fv=%b gf=%b food=(%0d,%0d) q=(%0d,%0d), need all 0",
               q_valid, busy, food_valid, grid_full, food_x, food_y, q_x, q_y);
    end
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || food_valid !== 1'b0 || food_x !== 6'd0 || food_y !== 6'd0) begin
      errors++;
      $display("[TB] FAIL stale_resp: busy=%b fv=%b food=(%0d,%0d), need 0 0 (0,0)", busy, food_valid, food_x, food_y);
    end
    base = query_count;
    @(negedge clk);
    place_req = 1'b1;
    repeat (4) @(negedge clk);
    place_req = 1'b0;
    #1;
    checks++;
    if (food_valid !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL busy_req_commit: fv=%b busy=%b, need 1 0", food_valid, busy);
    end
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || food_valid !== 1'b1 || query_count - base != 1) begin
      errors++;
      $display("[TB] FAIL busy_req_ignored: busy=%b fv=%b count=%0d, need 0 1 1", busy, food_valid, query_count - base);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    place_req = 1'b0;
    rnd_x     = '0;
    rnd_y     = '0;
    set_all_occ(1'b0);
    $display("[TB] starting food_placer bench");
    test_reset();
    test_basic_hit();
    test_range_reject();
    test_retry_stall();
    test_fallback_scan();
    test_full_grid();
    test_reset_and_ignore();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
